// File: rtl/product_bcd_conv_pkg.sv
// -----------------------------------------------------------------------------
// product_bcd_conv_pkg
// Shared definitions for the product-to-BCD converter:
//   - FSM state encoding (IDLE / SHIFT / DONE)
//   - BCD digit width
//   - 7-segment lookup constants, active-high {g,f,e,d,c,b,a}
// No ports; imported by the interface, the top and the segment decoder.
// -----------------------------------------------------------------------------
package product_bcd_conv_pkg;

  localparam int BCD_W = 4;
  localparam int SEG_W = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Segment patterns for digits 0..9 packed with digit 0 in the LSBs.
  localparam logic [10*SEG_W-1:0] SEG_LUT = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
    7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;
  localparam logic [SEG_W-1:0] SEG_ZERO  = SEG_LUT[SEG_W-1:0];

endpackage

// File: rtl/product_bcd_conv_if.sv
// -----------------------------------------------------------------------------
// product_bcd_conv_if
// Handshake/data bundle between the multiplier side (master) and the BCD
// converter (slave).
//   start : request conversion of din (master -> slave)
//   din   : binary value to convert   (master -> slave)
//   busy  : converter in SHIFT/DONE   (slave -> master)
//   done  : one-cycle pulse, bcd updated (slave -> master)
//   bcd   : packed BCD result, most significant digit in MSB nibble
//   seg   : per-digit 7-segment patterns, only when SEVEN_SEG_EN is defined
// -----------------------------------------------------------------------------
interface product_bcd_conv_if #(
  parameter int DIN_W  = 8,
  parameter int DIGITS = 3
) ();
  logic              start;
  logic [DIN_W-1:0]  din;
  logic              busy;
  logic              done;
  logic [4*DIGITS-1:0] bcd;
`ifdef SEVEN_SEG_EN
  logic [7*DIGITS-1:0] seg;
`endif

  modport master (
    output start,
    output din,
    input  busy,
    input  done,
    input  bcd
`ifdef SEVEN_SEG_EN
    , input seg
`endif
  );

  modport slave (
    input  start,
    input  din,
    output busy,
    output done,
    output bcd
`ifdef SEVEN_SEG_EN
    , output seg
`endif
  );
endinterface

// File: rtl/product_bcd_conv_bcd_to_7seg.sv
// -----------------------------------------------------------------------------
// product_bcd_conv_bcd_to_7seg  (bcd_to_7seg nibble decoder)
// Combinational decode of one BCD nibble into active-high {g,f,e,d,c,b,a}.
// Nibbles above 9 blank the digit.
//   nibble_i : BCD digit
//   seg_o    : segment pattern
// -----------------------------------------------------------------------------
module product_bcd_conv_bcd_to_7seg
  import product_bcd_conv_pkg::*;
(
  input  logic [BCD_W-1:0] nibble_i,
  output logic [SEG_W-1:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (nibble_i <= 4'd9) begin
      seg_o = SEG_LUT[int'(nibble_i)*SEG_W +: SEG_W];
    end
  end

endmodule

// File: rtl/product_bcd_conv.sv
// -----------------------------------------------------------------------------
// product_bcd_conv
// Sequential double-dabble converter: turns the multiplier's binary product
// into packed BCD, one input bit per clock. Results are held until the next
// conversion completes; partial results never reach the outputs.
// Optional feature macro: SEVEN_SEG_EN adds a registered 7-segment decode.
// Ports:
//   clk   : system clock, all state on posedge
//   reset : synchronous active-high reset
//   bus   : product_bcd_conv_if.slave (start, din, busy, done, bcd[, seg])
// Parameters:
//   DIN_W  : binary input width (one SHIFT cycle per bit)
//   DIGITS : BCD digits out; 10**DIGITS must exceed 2**DIN_W-1
// -----------------------------------------------------------------------------
module product_bcd_conv
  import product_bcd_conv_pkg::*;
#(
  parameter int DIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                reset,
  product_bcd_conv_if.slave   bus
);

  localparam int SCR_W = BCD_W * DIGITS;
  localparam int CNT_W = $clog2(DIN_W + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DIN_W);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [DIN_W-1:0]   shreg_q;
  logic [SCR_W-1:0]   scratch_q;
  logic [SCR_W-1:0]   scratch_adj;
  logic               busy_q;
  logic               done_q;
  logic [SCR_W-1:0]   bcd_q;

  // Add-3 correction: a digit of 5..9 would become >=10 after doubling,
  // so pre-bias it so the shift carries into the next digit.
  function automatic logic [BCD_W-1:0] add3_fix(input logic [BCD_W-1:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  always_comb begin
    scratch_adj = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      scratch_adj[i*BCD_W +: BCD_W] = add3_fix(scratch_q[i*BCD_W +: BCD_W]);
    end
  end

`ifdef SEVEN_SEG_EN
  logic [SEG_W*DIGITS-1:0] seg_next;
  logic [SEG_W*DIGITS-1:0] seg_q;

  for (genvar g = 0; g < DIGITS; g++) begin : g_seg
    product_bcd_conv_bcd_to_7seg u_dec (
      .nibble_i (scratch_q[g*BCD_W +: BCD_W]),
      .seg_o    (seg_next[g*SEG_W +: SEG_W])
    );
  end

  assign bus.seg = seg_q;
`endif

  // FSM with registered outputs; reset also clears the datapath so a
  // reset mid-conversion leaves nothing stale behind.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      scratch_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
`ifdef SEVEN_SEG_EN
      seg_q     <= {DIGITS{SEG_ZERO}};
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            shreg_q   <= bus.din;
            scratch_q <= '0;
            cnt_q     <= CNT_INIT;
            busy_q    <= 1'b1;
            state_q   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // Correct first, then shift; the top scratch bit falls off,
          // which cannot happen while the DIGITS sizing rule holds.
          {scratch_q, shreg_q} <= {scratch_adj, shreg_q} << 1;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          bcd_q   <= scratch_q;
`ifdef SEVEN_SEG_EN
          seg_q   <= seg_next;
`endif
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.bcd  = bcd_q;

endmodule

// File: tb/tb_product_bcd_conv.sv
// -----------------------------------------------------------------------------
// tb_product_bcd_conv
// Self-checking bench for product_bcd_conv: vector table, hand sequences for
// busy/reset corner cases, randomized values and a full 0..255 sweep, all
// checked against a divide/modulo decimal digit model.
// -----------------------------------------------------------------------------
module tb_product_bcd_conv;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  product_bcd_conv_if #(.DIN_W(8), .DIGITS(3)) bus ();

  product_bcd_conv #(.DIN_W(8), .DIGITS(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  din;
    logic [11:0] bcd;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [11:0] model_bcd(input int v);
    int h, t, o;
    h = v / 100;
    t = (v / 10) % 10;
    o = v % 10;
    return {h[3:0], t[3:0], o[3:0]};
  endfunction

  function automatic logic [6:0] model_seg_digit(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [20:0] model_seg(input logic [11:0] b);
    return {model_seg_digit(b[11:8]), model_seg_digit(b[7:4]), model_seg_digit(b[3:0])};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Advance at least one edge, sampling on negedge, until done or bound.
  task automatic wait_done(output int edges);
    edges = 0;
    do begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end while (!bus.done && edges < 20);
  endtask

  task automatic do_conv(input logic [7:0] v, input logic [11:0] exp, input string name);
    int edges;
    @(negedge clk);
    bus.start = 1'b1;
    bus.din   = v;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.din   = 8'($urandom);
    chk({name, "_busy_run"}, 32'(bus.busy), 32'd1);
    wait_done(edges);
    chk({name, "_latency"}, 32'(edges), 32'd9);
    chk({name, "_bcd"}, 32'(bus.bcd), 32'(exp));
    chk({name, "_busy_end"}, 32'(bus.busy), 32'd0);
`ifdef SEVEN_SEG_EN
    chk({name, "_seg"}, 32'(bus.seg), 32'(model_seg(exp)));
`endif
    @(negedge clk);
    chk({name, "_done_pulse"}, 32'(bus.done), 32'd0);
    chk({name, "_hold"}, 32'(bus.bcd), 32'(exp));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;
    int n_done;
    int n_busy;
    int first_k;
    logic [7:0]  dv[1:12];
    logic [11:0] first_bcd;
    logic [7:0]  rv;

    vecs[0] = '{8'd0,   12'h000};
    vecs[1] = '{8'd225, 12'h225};
    vecs[2] = '{8'd255, 12'h255};
    vecs[3] = '{8'd99,  12'h099};
    vecs[4] = '{8'd128, 12'h128};
    vecs[5] = '{8'd9,   12'h009};
    vecs[6] = '{8'd100, 12'h100};

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.din   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_bcd",  32'(bus.bcd),  32'd0);
`ifdef SEVEN_SEG_EN
    chk("rst_seg",  32'(bus.seg),  32'h0FDFBF);
`endif
    reset = 1'b0;

    // Table-driven known values (first entry is the din=0 case).
    for (int i = 0; i < 7; i++) begin
      do_conv(vecs[i].din, vecs[i].bcd, $sformatf("vec%0d", i));
    end
`ifdef SEVEN_SEG_EN
    do_conv(8'd225, 12'h225, "seg225");
    chk("seg225_explicit", 32'(bus.seg), 32'({7'h5B, 7'h5B, 7'h6D}));
`endif

    // start held high for 12 cycles with din changing every cycle.
    @(negedge clk);
    bus.start = 1'b1;
    n_done  = 0;
    first_k = 0;
    first_bcd = '0;
    for (int k = 1; k <= 12; k++) begin
      rv = 8'($urandom);
      dv[k] = rv;
      bus.din = rv;
      @(posedge clk);
      @(negedge clk);
      if (bus.done) begin
        n_done++;
        if (first_k == 0) begin
          first_k = k;
          first_bcd = bus.bcd;
        end
      end
    end
    bus.start = 1'b0;
    chk("held_start_ndone", 32'(n_done), 32'd1);
    chk("held_start_done_edge", 32'(first_k), 32'd10);
    chk("held_start_bcd", 32'(first_bcd), 32'(model_bcd(int'(dv[1]))));
    wait_done(edges);
    chk("restart_latency", 32'(edges), 32'd8);
    chk("restart_bcd", 32'(bus.bcd), 32'(model_bcd(int'(dv[11]))));
    @(negedge clk);

    // Reset four cycles into a din=200 conversion.
    @(negedge clk);
    bus.start = 1'b1;
    bus.din   = 8'd200;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_bcd",  32'(bus.bcd),  32'd0);
`ifdef SEVEN_SEG_EN
    chk("midrst_seg",  32'(bus.seg),  32'h0FDFBF);
`endif
    reset = 1'b0;
    n_done = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done) n_done++;
    end
    chk("midrst_no_done", 32'(n_done), 32'd0);
    do_conv(8'd37, 12'h037, "after_rst37");

    // Reset and start in the same cycle: reset wins.
    @(negedge clk);
    reset     = 1'b1;
    bus.start = 1'b1;
    bus.din   = 8'd77;
    @(posedge clk);
    @(negedge clk);
    reset     = 1'b0;
    bus.start = 1'b0;
    n_done = 0;
    n_busy = 0;
    for (int k = 0; k < 12; k++) begin
      if (bus.busy) n_busy++;
      @(posedge clk);
      @(negedge clk);
      if (bus.done) n_done++;
    end
    chk("rst_start_busy", 32'(n_busy), 32'd0);
    chk("rst_start_done", 32'(n_done), 32'd0);
    chk("rst_start_bcd",  32'(bus.bcd), 32'd0);

    // Randomized values against the digit model.
    for (int i = 0; i < 30; i++) begin
      rv = 8'($urandom_range(0, 255));
      do_conv(rv, model_bcd(int'(rv)), $sformatf("rand%0d_%0d", i, rv));
    end

    // Back-to-back sweep of every input: start stays high, din advances
    // in each done cycle so consecutive conversions are one IDLE apart.
    @(negedge clk);
    bus.start = 1'b1;
    for (int v = 0; v < 256; v++) begin
      bus.din = 8'(v);
      wait_done(edges);
      chk($sformatf("sweep%0d_spacing", v), 32'(edges), 32'd10);
      chk($sformatf("sweep%0d_bcd", v), 32'(bus.bcd), 32'(model_bcd(v)));
`ifdef SEVEN_SEG_EN
      chk($sformatf("sweep%0d_seg", v), 32'(bus.seg), 32'(model_seg(model_bcd(v))));
`endif
    end
    bus.start = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
